// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory bus around dmem_arbiter.
// slave: the arbiter's view. master: the requesters and memory.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;

    logic              err;
    logic              busy;

    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_WEN;
    logic              MEM_REN;
    logic              WRITE_MF;
    logic [DATA_W-1:0] MEM_RDATA;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_done, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_done, p1_rdata,
        output err, busy,
        output MEM_ADDR, MEM_WDATA, MEM_WEN, MEM_REN, WRITE_MF,
        input  MEM_RDATA
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_done, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_done, p1_rdata,
        input  err, busy,
        input  MEM_ADDR, MEM_WDATA, MEM_WEN, MEM_REN, WRITE_MF,
        output MEM_RDATA
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Port 0 = load/store stage, port 1 = loader/debug DMA.
// Optional: define DMEM_ARB_ADDR_CHECK_EN to reject addresses >= DEPTH with err.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              p0_gnt_q, p0_gnt_d, p1_gnt_q, p1_gnt_d;
    logic              p0_done_q, p0_done_d, p1_done_q, p1_done_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic              err_q, err_d;
    logic              in_range;
    logic              winner;
    logic              mem_access;

`ifdef DMEM_ARB_ADDR_CHECK_EN
    assign in_range = (addr_q < ADDR_W'(DEPTH));
`else
    logic unused_depth;
    assign in_range     = 1'b1;
    assign unused_depth = ^DEPTH;
`endif

    // On a tie the port that was not granted last wins.
    assign winner = (bus.p0_req && bus.p1_req) ? ~last_q : bus.p1_req;

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
        last_d     = last_q;
        p0_gnt_d   = 1'b0;
        p1_gnt_d   = 1'b0;
        p0_done_d  = 1'b0;
        p1_done_d  = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.p0_req || bus.p1_req) begin
                    owner_d = winner;
                    last_d  = winner;
                    if (winner) begin
                        we_d     = bus.p1_we;
                        addr_d   = bus.p1_addr;
                        wdata_d  = bus.p1_wdata;
                        p1_gnt_d = 1'b1;
                    end else begin
                        we_d     = bus.p0_we;
                        addr_d   = bus.p0_addr;
                        wdata_d  = bus.p0_wdata;
                        p0_gnt_d = 1'b1;
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!in_range || we_q) begin
                    // Writes and rejected accesses complete without a response cycle.
                    p0_done_d = ~owner_q;
                    p1_done_d = owner_q;
                    err_d     = ~in_range;
                    state_d   = StIdle;
                end else begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (owner_q) begin
                    p1_rdata_d = bus.MEM_RDATA;
                end else begin
                    p0_rdata_d = bus.MEM_RDATA;
                end
                p0_done_d = ~owner_q;
                p1_done_d = owner_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; synchronous reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            p0_gnt_q   <= 1'b0;
            p1_gnt_q   <= 1'b0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            p0_gnt_q   <= p0_gnt_d;
            p1_gnt_q   <= p1_gnt_d;
            p0_done_q  <= p0_done_d;
            p1_done_q  <= p1_done_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            err_q      <= err_d;
        end
    end

    // Strobes are gated by rst so nothing commits during a reset cycle.
    assign mem_access = (state_q == StAccess) && in_range && !rst;

    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.MEM_WEN   = mem_access && we_q;
    assign bus.WRITE_MF  = mem_access && we_q;
    assign bus.MEM_REN   = mem_access && !we_q;
    assign bus.p0_gnt    = p0_gnt_q;
    assign bus.p1_gnt    = p1_gnt_q;
    assign bus.p0_done   = p0_done_q;
    assign bus.p1_done   = p1_done_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle-by-cycle vector table plus hand sequences.
module tb_dmem_arbiter;
    localparam logic [8:0] FP0G = 9'h100, FP0D = 9'h080, FP1G = 9'h040, FP1D = 9'h020;
    localparam logic [8:0] FERR = 9'h010, FBSY = 9'h008, FWEN = 9'h004, FREN = 9'h002;
    localparam logic [8:0] FWMF = 9'h001;
    localparam logic [8:0] WR   = FBSY | FWEN | FWMF;
    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] W7  = 32'h11111111;
    localparam logic [31:0] W3  = 32'h12345678;
    localparam logic [31:0] A10 = 32'h0000000A;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] mem [64];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port memory model.
    always @(posedge clk) begin
        if (bus.MEM_WEN) mem[bus.MEM_ADDR[5:0]] <= bus.MEM_WDATA;
        if (bus.MEM_REN) bus.MEM_RDATA <= mem[bus.MEM_ADDR[5:0]];
    end

    typedef struct packed {
        logic        rst;
        logic        p0_req;
        logic        p0_we;
        logic [31:0] p0_addr;
        logic [31:0] p0_wdata;
        logic        p1_req;
        logic        p1_we;
        logic [31:0] p1_addr;
        logic [31:0] p1_wdata;
        logic [8:0]  flags;
        logic [31:0] addr;
        logic [31:0] r0;
        logic [31:0] r1;
    } vec_t;

    vec_t vecs [24];

    function automatic logic [8:0] cur_flags();
        return {bus.p0_gnt, bus.p0_done, bus.p1_gnt, bus.p1_done, bus.err, bus.busy,
                bus.MEM_WEN, bus.MEM_REN, bus.WRITE_MF};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then let outputs settle.
    task automatic drive(input logic r, input logic q0, input logic w0,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic q1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        @(negedge clk);
        rst          = r;
        bus.p0_req   = q0;
        bus.p0_we    = w0;
        bus.p0_addr  = a0;
        bus.p0_wdata = d0;
        bus.p1_req   = q1;
        bus.p1_we    = w1;
        bus.p1_addr  = a1;
        bus.p1_wdata = d1;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 64; i++) mem[i] = i;
        bus.MEM_RDATA = '0;
        rst = 1'b1;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;

        // rst, p0 {req,we,addr,wdata}, p1 {req,we,addr,wdata}, flags, MEM_ADDR, rdata0, rdata1
        // Reset with a request present, then p0 write 5 followed by read 5.
        vecs[0]  = '{1, 1, 1, 5, DB, 0, 0, 0, 0, 9'h0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 5, DB, 0, 0, 0, 0, 9'h0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 5, DB, 0, 0, 0, 0, 9'h0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 5, 0, 0, 0, 0, 0, FP0G | WR, 5, 0, 0};
        vecs[4]  = '{0, 1, 0, 5, 0, 0, 0, 0, 0, FP0D, 5, 0, 0};
        vecs[5]  = '{0, 0, 0, 5, 0, 0, 0, 0, 0, FP0G | FBSY | FREN, 5, 0, 0};
        vecs[6]  = '{0, 0, 0, 5, 0, 0, 0, 0, 0, FBSY, 5, 0, 0};
        vecs[7]  = '{0, 0, 0, 5, 0, 0, 0, 0, 0, FP0D, 5, DB, 0};
        // Reset, then both ports contend for two transactions each.
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 9'h0, 5, DB, 0};
        vecs[9]  = '{0, 1, 1, 7, W7, 1, 0, 10, 0, 9'h0, 0, 0, 0};
        vecs[10] = '{0, 1, 1, 7, W7, 1, 0, 10, 0, FP0G | WR, 7, 0, 0};
        vecs[11] = '{0, 1, 1, 7, W7, 1, 0, 10, 0, FP0D, 7, 0, 0};
        vecs[12] = '{0, 1, 1, 7, W7, 1, 0, 10, 0, FP1G | FBSY | FREN, 10, 0, 0};
        vecs[13] = '{0, 1, 1, 7, W7, 1, 0, 10, 0, FBSY, 10, 0, 0};
        vecs[14] = '{0, 1, 1, 7, W7, 1, 0, 10, 0, FP1D, 10, 0, A10};
        vecs[15] = '{0, 0, 0, 0, 0, 1, 0, 10, 0, FP0G | WR, 7, 0, A10};
        vecs[16] = '{0, 0, 0, 0, 0, 1, 0, 10, 0, FP0D, 7, 0, A10};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 10, 0, FP1G | FBSY | FREN, 10, 0, A10};
        vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, FBSY, 10, 0, A10};
        vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, FP1D, 10, 0, A10};
        vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h0, 10, 0, A10};
        // p0 write to 3 killed by reset during its ACCESS cycle.
        vecs[21] = '{0, 1, 1, 3, W3, 0, 0, 0, 0, 9'h0, 10, 0, A10};
        vecs[22] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, FP0G | FBSY, 3, 0, A10};
        vecs[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h0, 0, 0, 0};

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].p0_req, vecs[i].p0_we, vecs[i].p0_addr,
                  vecs[i].p0_wdata, vecs[i].p1_req, vecs[i].p1_we, vecs[i].p1_addr,
                  vecs[i].p1_wdata);
            chk($sformatf("vec%0d_flags", i), 32'(cur_flags()), 32'(vecs[i].flags));
            chk($sformatf("vec%0d_mem_addr", i), bus.MEM_ADDR, vecs[i].addr);
            chk($sformatf("vec%0d_p0_rdata", i), bus.p0_rdata, vecs[i].r0);
            chk($sformatf("vec%0d_p1_rdata", i), bus.p1_rdata, vecs[i].r1);
        end

        // Out-of-range read of address 40.
        drive(0, 1, 0, 40, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("oor_gnt", 32'(bus.p0_gnt), 1);
`ifdef DMEM_ARB_ADDR_CHECK_EN
        chk("oor_ren_blocked", 32'(bus.MEM_REN), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("oor_done", 32'(bus.p0_done), 1);
        chk("oor_err", 32'(bus.err), 1);
        chk("oor_rdata_kept", bus.p0_rdata, 0);
        chk("oor_mem_rdata_untouched", 32'(bus.busy), 0);
`else
        chk("oor_ren_passed", 32'(bus.MEM_REN), 1);
        chk("oor_addr_passed", bus.MEM_ADDR, 40);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("oor_resp_busy", 32'(bus.busy), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("oor_done", 32'(bus.p0_done), 1);
        chk("oor_err", 32'(bus.err), 0);
        chk("oor_rdata", bus.p0_rdata, 40);
`endif

        // In-range read of address 5 afterwards completes cleanly.
        drive(0, 1, 0, 5, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd5_ren", 32'(bus.MEM_REN), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd5_no_early_done", 32'(bus.p0_done), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd5_done", 32'(bus.p0_done), 1);
        chk("rd5_err", 32'(bus.err), 0);
        chk("rd5_rdata", bus.p0_rdata, DB);

        // Memory contents after the sequence.
        chk("mem3_unwritten", mem[3], 3);
        chk("mem5", mem[5], DB);
        chk("mem7", mem[7], W7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters. Port 0 is the processor load/store stage; port 1 is the loader/debug DMA. Each transaction gets a grant, one memory access cycle, and a done pulse with read data. Sits directly in front of the data memory and drives its address, write-data, write-enable, read-enable and write-mask-force strobes.

Parameters:
ADDR_W, 32, width of requester and memory address
DATA_W, 32, data width
DEPTH, 32, number of valid memory words (used by the optional address check)

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
p0_req  in  1  port 0 transaction request (level)
p0_we  in  1  1 = write, 0 = read
p0_addr  in  ADDR_W  word address
p0_wdata  in  DATA_W  write data
p0_gnt  out  1  one-cycle grant pulse
p0_done  out  1  one-cycle completion pulse
p0_rdata  out  DATA_W  read data, valid while p0_done=1
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata  same as p0 for port 1
err  out  1  out-of-range flag, valid with done (see Optional Feature)
busy  out  1  1 when state != IDLE
MEM_ADDR  out  ADDR_W  memory address
MEM_WDATA  out  DATA_W  memory write data
MEM_WEN  out  1  memory write enable
MEM_REN  out  1  memory read enable
WRITE_MF  out  1  memory write qualifier; asserted together with MEM_WEN
MEM_RDATA  in  DATA_W  memory read data, registered by memory one cycle after MEM_REN

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, ACCESS, RESP.
- IDLE: sample p0_req/p1_req.
  - None asserted: stay in IDLE.
  - Otherwise pick a winner, capture its we/addr/wdata plus an owner bit, and go to ACCESS.
  - The winner's gnt is registered and is high for exactly the ACCESS cycle.
- Arbitration: round-robin on a last-owner bit.
  - Single request: that port wins.
  - Both requesting: the port not granted last wins.
  - After reset, last-owner = 1, so port 0 wins the first tie.
- ACCESS: MEM_ADDR/MEM_WDATA come from the captured registers.
  - Write: MEM_WEN=WRITE_MF=1, MEM_REN=0. Next state IDLE; owner done <= 1.
  - Read: MEM_REN=1, MEM_WEN=WRITE_MF=0. Next state RESP.
- RESP: all strobes 0. Owner rdata <= MEM_RDATA, owner done <= 1, next state IDLE.
- Latency, counted from the IDLE cycle that samples req (cycle 0):
  - gnt in cycle 1.
  - Write done in cycle 2.
  - Read done plus rdata in cycle 3.
- Request protocol:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - req still high at the next IDLE sample means a new transaction (back-to-back allowed).
  - Requester drops req in the gnt cycle if it has no further work.
- Throughput: at most one memory access per 2 cycles (write) or 3 cycles (read). Non-owner done/gnt stay 0.
- pX_rdata holds its last value until the next read completion for that port.
- Outside ACCESS, MEM_WEN, MEM_REN and WRITE_MF are 0. MEM_ADDR/MEM_WDATA hold the captured values.
- Reset (any state, including mid-transaction):
  - state = IDLE; gnt, done, rdata, err, captured regs and owner all 0; last-owner = 1.
  - MEM_WEN, WRITE_MF and MEM_REN are gated combinationally by rst, so no write commits in a reset cycle.
  - The in-flight transaction is dropped with no done.
- A req asserted in the reset cycle is ignored; it is sampled in the first IDLE after rst falls.

Optional Feature:
DMEM_ARB_ADDR_CHECK_EN
- Defined: a captured addr >= DEPTH is not issued.
  - In ACCESS all strobes stay 0 and the state goes straight to IDLE.
  - Owner done=1 and err=1 in the next cycle; rdata is unchanged.
  - err is 0 on every in-range completion.
- Undefined: no check; the address passes through unmodified; err is tied 0.

Test Plan:
- Port 0 writes addr 5 = 0xDEADBEEF, then reads addr 5 -> p0_gnt in cycles 1 and 3 after the first req sample; p0_done with p0_rdata = 0xDEADBEEF exactly 3 cycles after the read's sample.
- Both ports request in the same cycle after reset, held for 2 transactions each -> grant order p0, p1, p0, p1; no overlapping ACCESS cycles; exactly one MEM_WEN/MEM_REN pulse per grant.
- Port 1 read of addr 10 whose initial content is 0x0000000A, while port 0 is idle -> p1_done with p1_rdata = 0x0000000A; p0_done and p0_gnt stay 0 throughout.
- rst asserted during the ACCESS cycle of a p0 write of 0x12345678 to addr 3 -> MEM_WEN=0 that cycle; addr 3 keeps its old value; no p0_done; busy=0 the cycle after.
- With DMEM_ARB_ADDR_CHECK_EN defined, p0 reads addr 40 with DEPTH=32 -> MEM_REN never asserted; p0_done=err=1 2 cycles after the sample; an in-range read that follows returns err=0.
